// File: rtl/systolic_gemm_engine.sv
// systolic_gemm_engine: output-stationary ARR_SIZE x ARR_SIZE GEMM array with input skew and row drain.
// Define SYSTOLIC_SAT_EN for saturating accumulation; otherwise accumulators wrap.
module systolic_gemm_engine #(
    parameter int ARR_SIZE = 4,
    parameter int DATA_W   = 16,
    parameter int ACC_W    = 40,
    parameter int K_MAX    = 256,
    parameter int K_W      = $clog2(K_MAX + 1)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_mode,
    input  logic                        i_start,
    input  logic [K_W-1:0]              i_k_len,
    input  logic                        i_valid,
    output logic                        o_ready,
    input  logic [ARR_SIZE*DATA_W-1:0]  i_a,
    input  logic [ARR_SIZE*DATA_W-1:0]  i_b,
    output logic                        o_valid,
    input  logic                        i_ready,
    output logic [ARR_SIZE*ACC_W-1:0]   o_row,
    output logic [$clog2(ARR_SIZE)-1:0] o_row_idx,
    output logic                        o_busy,
    output logic                        o_done
);
    localparam int N     = ARR_SIZE;
    localparam int IDX_W = $clog2(ARR_SIZE);
    localparam int FL_W  = $clog2(2 * ARR_SIZE);
    localparam int EW    = ((ACC_W > 2 * DATA_W) ? ACC_W : 2 * DATA_W) + 2;

    typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DRAIN} state_t;

    state_t             state_q, state_d;
    logic [K_W-1:0]     k_len_q, k_len_d, beat_q, beat_d, k_clamp;
    logic [FL_W-1:0]    fl_q, fl_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               mode_q, mode_d, done_q, done_d;
    logic               go, en, clr;
    logic [DATA_W-1:0]  a_src [N];
    logic [DATA_W-1:0]  b_src [N];
    logic [DATA_W-1:0]  a_sk_q [N][N];
    logic [DATA_W-1:0]  b_sk_q [N][N];
    logic [DATA_W-1:0]  a_in [N][N];
    logic [DATA_W-1:0]  b_in [N][N];
    logic [DATA_W-1:0]  a_q [N][N];
    logic [DATA_W-1:0]  b_q [N][N];
    logic [ACC_W-1:0]   acc_q [N][N];
    logic [ACC_W-1:0]   acc_d [N][N];

    // Extension to EW bits keeps the full product exact in both modes.
    function automatic logic [EW-1:0] mul(input logic [DATA_W-1:0] x, input logic [DATA_W-1:0] y, input logic s);
        return {{(EW-DATA_W){s & x[DATA_W-1]}}, x} * {{(EW-DATA_W){s & y[DATA_W-1]}}, y};
    endfunction

`ifdef SYSTOLIC_SAT_EN
    localparam logic [EW-1:0] SMAX = {{(EW-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
    localparam logic [EW-1:0] SMIN = {{(EW-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};
    localparam logic [EW-1:0] UMAX = {{(EW-ACC_W){1'b0}}, {ACC_W{1'b1}}};

    logic sat_q [N][N];
    logic sat_d [N][N];

    function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] acc, input logic [EW-1:0] p, input logic s);
        logic [EW-1:0] sum, hi, lo;
        logic          ovf, unf;
        sum = {{(EW-ACC_W){s & acc[ACC_W-1]}}, acc} + p;
        hi  = s ? SMAX : UMAX;
        lo  = s ? SMIN : '0;
        ovf = $signed(sum) > $signed(hi);
        unf = $signed(sum) < $signed(lo);
        return {ovf | unf, ovf ? hi[ACC_W-1:0] : unf ? lo[ACC_W-1:0] : sum[ACC_W-1:0]};
    endfunction
`endif

    assign go  = (state_q == IDLE) && i_start;
    assign en  = ((state_q == LOAD) && i_valid) || (state_q == FLUSH);
    assign clr = rst || go;

    assign o_ready   = state_q == LOAD;
    assign o_valid   = state_q == DRAIN;
    assign o_busy    = state_q != IDLE;
    assign o_done    = done_q;
    assign o_row_idx = idx_q;

    always_comb begin
        o_row = '0;
        for (int c = 0; c < N; c++) o_row[c*ACC_W +: ACC_W] = (state_q == DRAIN) ? acc_q[idx_q][c] : '0;
    end

    always_comb begin
        k_clamp = (i_k_len > K_W'(K_MAX)) ? K_W'(K_MAX) : i_k_len;
        state_d = state_q;
        k_len_d = k_len_q;
        beat_d  = beat_q;
        fl_d    = fl_q;
        idx_d   = idx_q;
        mode_d  = mode_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: if (i_start) begin
                mode_d  = i_mode;
                k_len_d = k_clamp;
                beat_d  = '0;
                fl_d    = '0;
                idx_d   = '0;
                state_d = (k_clamp == '0) ? FLUSH : LOAD;
            end
            LOAD: if (i_valid) begin
                beat_d  = beat_q + K_W'(1);
                state_d = (beat_q == k_len_q - K_W'(1)) ? FLUSH : LOAD;
            end
            FLUSH: begin
                fl_d    = fl_q + FL_W'(1);
                state_d = (fl_q == FL_W'(2 * N - 2)) ? DRAIN : FLUSH;
            end
            DRAIN: if (i_ready) begin
                idx_d   = (idx_q == IDX_W'(N - 1)) ? '0 : idx_q + IDX_W'(1);
                done_d  = idx_q == IDX_W'(N - 1);
                state_d = (idx_q == IDX_W'(N - 1)) ? IDLE : DRAIN;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            k_len_q <= '0;
            beat_q  <= '0;
            fl_q    <= '0;
            idx_q   <= '0;
            mode_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_len_q <= k_len_d;
            beat_q  <= beat_d;
            fl_q    <= fl_d;
            idx_q   <= idx_d;
            mode_q  <= mode_d;
            done_q  <= done_d;
        end
    end

    // Zeros are injected during FLUSH so the tail of the wavefront drains through.
    always_comb begin
        for (int r = 0; r < N; r++) begin
            a_src[r] = (state_q == LOAD) ? i_a[r*DATA_W +: DATA_W] : '0;
            b_src[r] = (state_q == LOAD) ? i_b[r*DATA_W +: DATA_W] : '0;
        end
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                a_in[r][c] = (c == 0) ? ((r == 0) ? a_src[0] : a_sk_q[r][(r > 0) ? r - 1 : 0]) : a_q[r][(c > 0) ? c - 1 : 0];
                b_in[r][c] = (r == 0) ? ((c == 0) ? b_src[0] : b_sk_q[c][(c > 0) ? c - 1 : 0]) : b_q[(r > 0) ? r - 1 : 0][c];
`ifdef SYSTOLIC_SAT_EN
                {sat_d[r][c], acc_d[r][c]} = sat_q[r][c] ? {1'b1, acc_q[r][c]}
                                           : sat_add(acc_q[r][c], mul(a_in[r][c], b_in[r][c], mode_q), mode_q);
`else
                acc_d[r][c] = acc_q[r][c] + ACC_W'(mul(a_in[r][c], b_in[r][c], mode_q));
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int r = 0; r < N; r++) begin
            for (int i = 0; i < N; i++) begin
                if (clr) begin
                    a_sk_q[r][i] <= '0;
                    b_sk_q[r][i] <= '0;
                end else if (en) begin
                    a_sk_q[r][i] <= (i == 0) ? a_src[r] : a_sk_q[r][(i > 0) ? i - 1 : 0];
                    b_sk_q[r][i] <= (i == 0) ? b_src[r] : b_sk_q[r][(i > 0) ? i - 1 : 0];
                end
            end
            for (int c = 0; c < N; c++) begin
                if (clr) begin
                    a_q[r][c]   <= '0;
                    b_q[r][c]   <= '0;
                    acc_q[r][c] <= '0;
`ifdef SYSTOLIC_SAT_EN
                    sat_q[r][c] <= 1'b0;
`endif
                end else if (en) begin
                    a_q[r][c]   <= a_in[r][c];
                    b_q[r][c]   <= b_in[r][c];
                    acc_q[r][c] <= acc_d[r][c];
`ifdef SYSTOLIC_SAT_EN
                    sat_q[r][c] <= sat_d[r][c];
`endif
                end
            end
        end
    end
endmodule

// File: tb/tb_systolic_gemm_engine.sv
// tb_systolic_gemm_engine: directed checks of systolic_gemm_engine; a second instance with ACC_W=16
// shares all inputs and exercises wrap vs SYSTOLIC_SAT_EN behaviour.
module tb_systolic_gemm_engine;
    logic         clk = 1'b0, rst = 1'b1, mode = 1'b0, start = 1'b0, valid = 1'b0, ready_in = 1'b1;
    logic [8:0]   k_len = '0;
    logic [63:0]  a = '0, b = '0;
    logic         rdy0, vld0, busy0, done0, rdy1, vld1, busy1, done1;
    logic [159:0] row0;
    logic [63:0]  row1;
    logic [1:0]   idx0, idx1;
    int           n_tests = 0, n_fail = 0, cyc = 0, cyc_l, done_at, first_valid, rc;
    bit           saw_ready;
    logic [15:0]  A_m [4][8];
    logic [15:0]  B_m [8][4];
    logic [39:0]  res0 [4][4];
    logic [15:0]  res1 [4][4];

`ifdef SYSTOLIC_SAT_EN
    localparam logic [15:0] SAT_EXP = 16'hFFFF;
`else
    localparam logic [15:0] SAT_EXP = 16'h0002;
`endif

    systolic_gemm_engine dut0 (
        .clk(clk), .rst(rst), .i_mode(mode), .i_start(start), .i_k_len(k_len),
        .i_valid(valid), .o_ready(rdy0), .i_a(a), .i_b(b), .o_valid(vld0),
        .i_ready(ready_in), .o_row(row0), .o_row_idx(idx0), .o_busy(busy0), .o_done(done0)
    );

    systolic_gemm_engine #(.ACC_W(16)) dut1 (
        .clk(clk), .rst(rst), .i_mode(mode), .i_start(start), .i_k_len(k_len),
        .i_valid(valid), .o_ready(rdy1), .i_a(a), .i_b(b), .o_valid(vld1),
        .i_ready(ready_in), .o_row(row1), .o_row_idx(idx1), .o_busy(busy1), .o_done(done1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic fill(input logic [15:0] av, input logic [15:0] bv);
        for (int r = 0; r < 4; r++)
            for (int k = 0; k < 8; k++) begin
                A_m[r][k] = av;
                B_m[k][r] = bv;
            end
    endtask

    task automatic run_op(input logic md, input int k, input bit bubble, input int stall_row, input bit poke);
        int           guard, stall, beat;
        bit           fin;
        logic [159:0] held;
        guard = 0; stall = 0; beat = 0; fin = 0; held = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                res0[r][c] = 40'hEEEEEEEEEE;
                res1[r][c] = 16'hEEEE;
            end
        done_at = -1; first_valid = -1; saw_ready = 0; rc = 0; ready_in = 1'b1;
        mode = md; k_len = 9'(k); start = 1'b1;
        tick();
        start = 1'b0;
        cyc_l = cyc;
        while (!fin && guard < 200) begin
            if (rdy0) saw_ready = 1;
            if (vld0 && first_valid < 0) first_valid = cyc - cyc_l;
            valid = !rdy0;
            a = {4{16'h5A5A}};
            b = a;
            if (rdy0 && beat < k && !(bubble && guard % 2 == 1)) begin
                valid = 1'b1;
                for (int i = 0; i < 4; i++) begin
                    a[i*16 +: 16] = A_m[i][beat];
                    b[i*16 +: 16] = B_m[beat][i];
                end
                beat++;
            end
            ready_in = 1'b1;
            if (vld0 && int'(idx0) == stall_row) begin
                if (stall > 0) check("stall_hold", row0, held);
                held = row0;
                ready_in = stall == 3;
                if (!ready_in) stall++;
            end
            if (vld0 && ready_in) begin
                check("row_idx", idx0, rc);
                for (int c = 0; c < 4; c++) begin
                    res0[idx0][c] = row0[c*40 +: 40];
                    res1[idx0][c] = row1[c*16 +: 16];
                end
                rc++;
            end
            start = poke && busy0 && !rdy0;
            tick();
            guard++;
            if (done0) begin
                fin = 1;
                done_at = cyc - cyc_l;
            end
        end
        start = 1'b0;
        valid = 1'b0;
        ready_in = 1'b1;
        check("done_seen", fin, 1);
        check("rows_taken", rc, 4);
        check("busy_at_done", busy0, 0);
        tick();
        check("done_pulse", done0, 0);
    endtask

    task automatic check_res(input string tag, input bit ramp, input logic [39:0] e0, input bit chk1, input logic [15:0] e1);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                check($sformatf("%s_c%0d%0d", tag, r, c), res0[r][c], ramp ? 40'(4 * r + c) : e0);
                if (chk1) check($sformatf("%s_n%0d%0d", tag, r, c), res1[r][c], e1);
            end
    endtask

    initial begin
        repeat (3) tick();
        check("rst_ready", rdy0, 0);
        check("rst_valid", vld0, 0);
        check("rst_row", row0, 0);
        check("rst_idx", idx0, 0);
        check("rst_busy", busy0, 0);
        check("rst_done", done0, 0);
        rst = 1'b0;
        tick();

        for (int r = 0; r < 4; r++)
            for (int k = 0; k < 8; k++) begin
                A_m[r][k] = (r == k) ? 16'd1 : 16'd0;
                B_m[k][r] = 16'(4 * k + r);
            end
        mode = 1'b0; k_len = 9'd4; start = 1'b1;
        tick();
        start = 1'b0;
        check("start_busy", busy0, 1);
        check("start_ready", rdy0, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        run_op(0, 4, 0, -1, 0);
        check("id_first_valid", first_valid, 11);
        check("id_done_at", done_at, 15);
        check("id_saw_ready", saw_ready, 1);
        check_res("id", 1, 0, 0, 0);

        run_op(0, 4, 0, -1, 1);
        check("poke_done_at", done_at, 15);
        check_res("poke", 1, 0, 0, 0);

        run_op(0, 0, 0, -1, 0);
        check("k0_saw_ready", saw_ready, 0);
        check("k0_first_valid", first_valid, 7);
        check("k0_done_at", done_at, 11);
        check_res("k0", 0, 0, 1, 0);

        fill(16'hFFFF, 16'hFFFE);
        run_op(1, 3, 1, 1, 0);
        check("sgn_done_at", done_at, 19);
        check_res("sgn", 0, 40'd6, 1, 16'd6);

        fill(16'hFFFF, 16'hFFFF);
        run_op(0, 2, 0, -1, 0);
        check("sat_done_at", done_at, 13);
        check_res("sat", 0, 40'h1FFFC0002, 1, SAT_EXP);

        fill(16'd7, 16'd7);
        mode = 1'b0; k_len = 9'd8; start = 1'b1;
        tick();
        start = 1'b0;
        valid = 1'b1; a = {4{16'd7}}; b = a;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0; valid = 1'b0;
        check("abort_busy", busy0, 0);
        check("abort_ready", rdy0, 0);
        check("abort_valid", vld0, 0);
        check("abort_row", row0, 0);
        fill(16'd3, 16'd5);
        run_op(0, 1, 0, -1, 0);
        check("abort_first_valid", first_valid, 8);
        check("abort_done_at", done_at, 12);
        check_res("abort", 0, 40'd15, 1, 16'd15);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/systolic_gemm_engine.md
# systolic_gemm_engine

Parametrised output-stationary systolic matrix-multiply engine; the next generation of the team's fixed 4x4 MAC array. Computes C = A x B for an ARR_SIZE x K by K x ARR_SIZE operand pair with runtime-programmable K. Includes internal input skewing, a valid/ready operand stream, signed/unsigned mode, and a row-by-row result drain with backpressure. Sits between the operand SRAM readers and the result write-back path.

## Interface
- ARR_SIZE, 4: array dimension (rows = columns = lanes).
- DATA_W, 16: operand width per lane.
- ACC_W, 40: accumulator and result width per PE.
- K_MAX, 256: maximum programmable K.
- K_W, $clog2(K_MAX+1): width of i_k_len.

- clk  in  1  single clock, all state on rising edge.
- rst  in  1  reset, synchronous, active-high.
- i_mode  in  1  0 = unsigned operands, 1 = signed two's complement; sampled on accepted i_start.
- i_start  in  1  start pulse; honoured only in IDLE.
- i_k_len  in  K_W  number of operand beats K; sampled with i_start; values > K_MAX clamp to K_MAX.
- i_valid  in  1  operand beat valid.
- o_ready  out  1  engine accepts operand beat (high only in LOAD).
- i_a  in  ARR_SIZE*DATA_W  lane r = A[r][k].
- i_b  in  ARR_SIZE*DATA_W  lane c = B[k][c].
- o_valid  out  1  result row valid.
- i_ready  in  1  downstream accepts result row.
- o_row  out  ARR_SIZE*ACC_W  lane c = C[o_row_idx][c].
- o_row_idx  out  $clog2(ARR_SIZE)  row index of o_row.
- o_busy  out  1  high in any state except IDLE.
- o_done  out  1  one-cycle pulse after final row is accepted.

## Operation
- FSM states: IDLE, LOAD, FLUSH, DRAIN.
- IDLE: i_start=1 clears all accumulators and skew/pipe registers, latches i_mode and clamped K into k_len_q, and sets beat counter = 0. Next state is LOAD, or FLUSH if K=0.
- LOAD: o_ready=1. A beat is accepted when i_valid & o_ready. Each accepted beat advances the array one step (enable = 1). Non-accepted cycles freeze all skew, pipe, and accumulator registers; bubbles are legal. After beat K-1 is accepted, go to FLUSH.
- Skew: lane r of A is delayed r enabled steps before PE(r,0); lane c of B is delayed c steps before PE(0,c). A moves right and B moves down one PE per enabled step.
- PE(r,c), on an enabled step: acc <= acc + a_in*b_in, then registers a_in right and b_in down. The product is 2*DATA_W wide and is sign- or zero-extended to ACC_W per mode.
- FLUSH: enable forced to 1 and zeros are injected at all inputs for exactly 2*ARR_SIZE-1 cycles (counter). Then go to DRAIN; if K=0, accumulators stay 0.
- DRAIN: o_valid=1 and o_row = accumulator row o_row_idx, starting at 0. On o_valid & i_ready, o_row_idx increments. o_row/o_row_idx stay stable while i_ready=0. On acceptance of row ARR_SIZE-1, o_done=1 for one cycle and the FSM returns to IDLE.
- i_start outside IDLE is ignored; i_valid outside LOAD is ignored.
- rst at any point (including mid-LOAD or mid-DRAIN): next cycle is IDLE with all accumulators, skew registers, and counters cleared.

## Timing
- Reset values: o_ready=0, o_valid=0, o_row=0, o_row_idx=0, o_busy=0, o_done=0.
- Start accepted in cycle t: o_busy=1 and o_ready=1 from t+1.
- With no bubbles and no backpressure, the first o_valid appears K + 2*ARR_SIZE-1 cycles after LOAD entry. The full op takes K + 2*ARR_SIZE-1 + ARR_SIZE cycles from LOAD entry to o_done.
- o_done is registered and coincides with the first IDLE cycle. A new i_start is accepted in that same cycle.
- All outputs are registered; there are no combinational paths from i_valid/i_ready to o_ready/o_valid.

## Configuration
- SYSTOLIC_SAT_EN defined: each accumulate saturates at ACC_W bounds. In signed mode the bounds are -2^(ACC_W-1) and 2^(ACC_W-1)-1; in unsigned mode they are 0 and 2^ACC_W-1. A saturated accumulator holds its bound until cleared.
- SYSTOLIC_SAT_EN undefined: accumulation wraps modulo 2^ACC_W; no saturation logic is present.

## Test plan
- ARR_SIZE=4, K=4, unsigned, A=identity, B[k][c]=4k+c, no bubbles -> rows 0..3 = {0,1,2,3},{4,5,6,7},{8,9,10,11},{12,13,14,15}; o_done at LOAD entry +15 cycles.
- K=0 start -> LOAD skipped, 4 rows of all zeros drained, o_done, o_ready never asserted.
- Signed, K=3, all A=-1, all B=-2, i_valid toggling every other cycle and i_ready low 3 cycles in row 1 -> every C=6, and o_row held stable during the stall.
- ACC_W=16, unsigned, K=2, all operands 0xFFFF -> with SYSTOLIC_SAT_EN every C=0xFFFF; without it every C=0x0002.
- rst asserted on 2nd beat of K=8 LOAD, then new start with K=1, A=all 3, B=all 5 -> every C=15, with no residue from the aborted run.
- i_start pulsed during FLUSH and DRAIN -> ignored; results and o_done timing unchanged vs. a run without the pulses.
